ppu_chr_bridge: RTL and testbench

- Serves NES PPU pattern-table (CHR, ppu_addr[13]=0) accesses from the byte-wide SDRAM controller port, replacing the fixed direct CHR drive.
- Adds runtime CIRAM mirroring selection, 8 KB CHR banking, CHR-RAM write-through, a last-address hit buffer and a late-read counter.
- Sits between the cartridge PPU pins and the SDRAM request interface. It is enabled once the flash-to-SDRAM load completes.

---
 rtl/ppu_chr_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_ppu_chr_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_chr_bridge.sv
// ppu_chr_bridge: serves NES PPU pattern-table (CHR) accesses from a byte-wide
// memory request port. Provides CIRAM mirroring select, 8 KB CHR banking,
// optional CHR-RAM write-through, a single-entry last-address hit buffer and
// a saturating counter of reads whose strobe ended before data arrived.
module ppu_chr_bridge #(
  parameter int          ADDR_W      = 23,
  parameter int          BANK_W      = 4,
  parameter int unsigned CHR_BASE    = 0,
  parameter bit          CHR_RAM     = 1'b0,
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mirror_mode,
  input  logic [BANK_W-1:0] chr_bank,
  input  logic [13:0]       ppu_addr,
  input  logic              ppu_rd_n,
  input  logic              ppu_we_n,
  input  logic [7:0]        ppu_din,
  output logic [7:0]        ppu_dout,
  output logic              ppu_doe,
  output logic              vram_cs_n,
  output logic              vram_a10_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [7:0]        mem_wdata,
  output logic              mem_req,
  input  logic              mem_busy,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [CNT_W-1:0]  late_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_HOLD, S_DRAIN, S_WR_REQ
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] rd_sync_q, we_sync_q;
  logic                   rd_prev_q, we_prev_q;
  logic                   rd_lvl, we_lvl, rd_fall, rd_rise, we_fall;

  logic [7:0]        dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              req_q, req_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  late_q, late_d, late_inc;
  logic              gone_q, gone_d;        // strobe released during current read
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic [BANK_W-1:0] bank_prev_q;
  logic [1:0]        mirror_prev_q;

  logic [ADDR_W-1:0] map_addr;
  logic              is_chr, cfg_change, buf_hit, buf_match, rd_start, wr_start;

  assign rd_lvl  = rd_sync_q[SYNC_STAGES-1];
  assign we_lvl  = we_sync_q[SYNC_STAGES-1];
  assign rd_fall = rd_prev_q & ~rd_lvl;
  assign rd_rise = ~rd_prev_q & rd_lvl;
  assign we_fall = we_prev_q & ~we_lvl;

  assign map_addr   = ADDR_W'(CHR_BASE) + ADDR_W'({chr_bank, ppu_addr[12:0]});
  assign is_chr     = ~ppu_addr[13];
  assign cfg_change = (chr_bank != bank_prev_q) | (mirror_mode != mirror_prev_q);
  assign buf_match  = buf_valid_q & (buf_addr_q == map_addr);
  assign buf_hit    = buf_match & ~cfg_change;
  assign rd_start   = rd_fall & is_chr & enable;
  assign wr_start   = we_fall & is_chr & enable;
  assign late_inc   = (&late_q) ? late_q : late_q + CNT_W'(1);

  assign vram_cs_n  = ~ppu_addr[13];
  assign ppu_dout   = dout_q;
  // Output enable drops as soon as the strobe is seen released or the bridge is disabled.
  assign ppu_doe    = doe_q & enable & ~rd_lvl;
  assign mem_addr   = addr_q;
  assign mem_rw     = rw_q;
  assign mem_wdata  = wdata_q;
  assign mem_req    = req_q;
  assign late_count = late_q;

  // CIRAM A10 selection from the mirroring mode.
  always_comb begin
    vram_a10_n = 1'b0;
    case (mirror_mode)
      2'd0:    vram_a10_n = ppu_addr[11];
      2'd1:    vram_a10_n = ppu_addr[10];
      2'd2:    vram_a10_n = 1'b0;
      default: vram_a10_n = 1'b1;
    endcase
  end

  // Strobe synchronisers and edge-detect history; idle level of strobes is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= '1;
      we_sync_q <= '1;
      rd_prev_q <= 1'b1;
      we_prev_q <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], ppu_rd_n};
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], ppu_we_n};
      rd_prev_q <= rd_lvl;
      we_prev_q <= we_lvl;
    end
  end

  // Next-state and datapath decisions for the access state machine.
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    req_d       = req_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    late_d      = late_q;
    gone_d      = gone_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          gone_d = 1'b0;
          if (buf_hit) begin
            dout_d  = buf_data_q;
            doe_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            req_d   = 1'b1;
            rw_d    = 1'b0;
            addr_d  = map_addr;
            state_d = S_RD_REQ;
          end
        end else if (wr_start) begin
          if (buf_match) buf_valid_d = 1'b0;
          if (CHR_RAM) begin
            req_d   = 1'b1;
            rw_d    = 1'b1;
            addr_d  = map_addr;
            wdata_d = ppu_din;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (rd_rise) gone_d = 1'b1;
        if (!mem_busy) begin
          req_d = 1'b0;
          if (gone_q | rd_rise) begin
            late_d  = late_inc;
            state_d = S_DRAIN;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (rd_rise) gone_d = 1'b1;
        if (mem_rvalid) begin
          dout_d      = mem_rdata;
          buf_data_d  = mem_rdata;
          buf_addr_d  = addr_q;
          buf_valid_d = 1'b1;
          if (gone_q | rd_rise) begin
            late_d  = late_inc;
            state_d = S_IDLE;
          end else begin
            doe_d   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (rd_lvl) begin
          doe_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      S_WR_REQ: begin
        if (!mem_busy) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A bank or mirroring change makes the buffered byte untrustworthy.
    if (cfg_change) buf_valid_d = 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dout_q        <= '0;
      doe_q         <= 1'b0;
      req_q         <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      late_q        <= '0;
      gone_q        <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      bank_prev_q   <= '0;
      mirror_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      dout_q        <= dout_d;
      doe_q         <= doe_d;
      req_q         <= req_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      late_q        <= late_d;
      gone_q        <= gone_d;
      buf_valid_q   <= buf_valid_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      bank_prev_q   <= chr_bank;
      mirror_prev_q <= mirror_mode;
    end
  end

endmodule

// File: tb/tb_ppu_chr_bridge.sv
// Bench for ppu_chr_bridge. Main DUT: CHR_RAM=1, CHR_BASE=0, CNT_W=16.
// Second DUT shares every input: CHR_RAM=0, CHR_BASE=0x7FF000 (wraps), CNT_W=2.
// A bench memory controller answers the main DUT's requests.
module tb_ppu_chr_bridge;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [1:0]  mirror_mode;
  logic [3:0]  chr_bank;
  logic [13:0] ppu_addr;
  logic        ppu_rd_n, ppu_we_n;
  logic [7:0]  ppu_din;
  logic        mem_busy, mem_rvalid;
  logic [7:0]  mem_rdata;

  logic [7:0]  dout, d2_dout;
  logic        doe, d2_doe, cs_n, d2_cs_n, a10_n, d2_a10_n;
  logic [22:0] mem_addr, d2_mem_addr;
  logic        mem_rw, d2_mem_rw, mem_req, d2_mem_req;
  logic [7:0]  mem_wdata, d2_mem_wdata;
  logic [15:0] late;
  logic [1:0]  late2;

  initial forever #5 clk = ~clk;

  ppu_chr_bridge #(.ADDR_W(23), .BANK_W(4), .CHR_BASE(0), .CHR_RAM(1'b1),
                   .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mirror_mode(mirror_mode),
    .chr_bank(chr_bank), .ppu_addr(ppu_addr), .ppu_rd_n(ppu_rd_n), .ppu_we_n(ppu_we_n),
    .ppu_din(ppu_din), .ppu_dout(dout), .ppu_doe(doe), .vram_cs_n(cs_n),
    .vram_a10_n(a10_n), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .late_count(late));

  ppu_chr_bridge #(.ADDR_W(23), .BANK_W(4), .CHR_BASE(32'h7FF000), .CHR_RAM(1'b0),
                   .SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mirror_mode(mirror_mode),
    .chr_bank(chr_bank), .ppu_addr(ppu_addr), .ppu_rd_n(ppu_rd_n), .ppu_we_n(ppu_we_n),
    .ppu_din(ppu_din), .ppu_dout(d2_dout), .ppu_doe(d2_doe), .vram_cs_n(d2_cs_n),
    .vram_a10_n(d2_a10_n), .mem_addr(d2_mem_addr), .mem_rw(d2_mem_rw),
    .mem_wdata(d2_mem_wdata), .mem_req(d2_mem_req), .mem_busy(mem_busy),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .late_count(late2));

  int checks = 0;
  int failures = 0;

  // controller bookkeeping
  int rd_cnt = 0, wr_cnt = 0, drop_err = 0, d2_wr_seen = 0;
  int busy_hold = 0, lat = 3, pend_cnt = 0;
  bit req_wait = 1'b0;
  logic [22:0] last_rd_addr = '0, last_wr_addr = '0, d2_last_addr = '0;
  logic [7:0]  last_wr_data = '0, pend_data = '0;
  logic [7:0]  ctl_mem [logic [22:0]];

  // reference model: memory contents as the PPU wrote them, plus buffer state
  logic [7:0]  ref_mem [logic [22:0]];
  bit          ref_valid = 1'b0;
  logic [22:0] ref_addr = '0;
  logic [3:0]  ref_bank = 4'd2;

  function automatic logic [7:0] dflt(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ctl_rd(input logic [22:0] a);
    return ctl_mem.exists(a) ? ctl_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Memory controller: all activity on the falling edge, seen by the DUT at the next rising edge.
  initial begin
    mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_data;
        end
      end
      if (req_wait && !mem_req) drop_err++;
      mem_busy = (busy_hold > 0);
      if (busy_hold > 0) busy_hold--;
      req_wait = mem_req && mem_busy;
      if (mem_req && !mem_busy) begin
        if (mem_rw) begin
          wr_cnt++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          ctl_mem[mem_addr] = mem_wdata;
        end else begin
          rd_cnt++;
          last_rd_addr = mem_addr;
          pend_data = ctl_rd(mem_addr);
          pend_cnt = lat;
        end
      end
      if (d2_mem_req && d2_mem_rw) d2_wr_seen++;
      if (d2_mem_req) d2_last_addr = d2_mem_addr;
    end
  end

  task automatic set_bank(input logic [3:0] b);
    @(negedge clk);
    chr_bank = b;
    if (b != ref_bank) ref_valid = 1'b0;
    ref_bank = b;
    @(negedge clk);
  endtask

  // Full PPU read: strobe held until data is driven, then released.
  task automatic chr_read(input logic [13:0] a, input string nm);
    logic [22:0] map;
    bit exp_req, got;
    int r0, rel, hold_bad;
    logic [7:0] d;
    map = {6'b0, ref_bank, a[12:0]};
    exp_req = !(ref_valid && ref_addr == map);
    r0 = rd_cnt; got = 1'b0; d = '0; hold_bad = 0; rel = 99;
    @(negedge clk);
    ppu_addr = a; ppu_rd_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (doe) begin got = 1'b1; d = dout; break; end
    end
    repeat (2) begin @(negedge clk); if (!doe) hold_bad++; end
    ppu_rd_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!doe) begin rel = i; break; end
    end
    repeat (4) @(negedge clk);
    chk({nm, " doe"}, 32'(got), 32'd1);
    chk({nm, " dout"}, 32'(d), 32'(ref_rd(map)));
    chk({nm, " requests"}, 32'(rd_cnt - r0), 32'(exp_req));
    chk({nm, " doe held"}, 32'(hold_bad), 32'd0);
    chk({nm, " release<=3"}, 32'(rel <= 3), 32'd1);
    $display("read  %-16s addr=%04h map=%06h dout=%02h req=%0d", nm, a, map, d, rd_cnt - r0);
    ref_valid = 1'b1;
    ref_addr  = map;
  endtask

  task automatic chr_write(input logic [13:0] a, input logic [7:0] dat, input string nm);
    logic [22:0] map;
    int w0;
    map = {6'b0, ref_bank, a[12:0]};
    w0 = wr_cnt;
    @(negedge clk);
    ppu_addr = a; ppu_din = dat; ppu_we_n = 1'b0;
    repeat (4) @(negedge clk);
    ppu_we_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_cnt != w0) break;
    end
    repeat (3) @(negedge clk);
    chk({nm, " wr count"}, 32'(wr_cnt - w0), 32'd1);
    chk({nm, " wr addr"}, 32'(last_wr_addr), 32'(map));
    chk({nm, " wr data"}, 32'(last_wr_data), 32'(dat));
    $display("write %-16s addr=%04h map=%06h data=%02h", nm, a, map, dat);
    if (ref_valid && ref_addr == map) ref_valid = 1'b0;
    ref_mem[map] = dat;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [13:0] addr;
    logic        a10;
    logic        cs;
  } mir_vec_t;

  initial begin
    mir_vec_t vt [10];
    int r0, doe_hi, op;
    bit got;
    logic [13:0] a;
    logic [13:0] aset [4];
    logic [7:0] wd;

    vt[0] = '{2'd0, 14'h2400, 1'b0, 1'b0};
    vt[1] = '{2'd0, 14'h2800, 1'b1, 1'b0};
    vt[2] = '{2'd1, 14'h2400, 1'b1, 1'b0};
    vt[3] = '{2'd1, 14'h2800, 1'b0, 1'b0};
    vt[4] = '{2'd2, 14'h2400, 1'b0, 1'b0};
    vt[5] = '{2'd2, 14'h2800, 1'b0, 1'b0};
    vt[6] = '{2'd3, 14'h2400, 1'b1, 1'b0};
    vt[7] = '{2'd3, 14'h2800, 1'b1, 1'b0};
    vt[8] = '{2'd0, 14'h0800, 1'b1, 1'b1};
    vt[9] = '{2'd1, 14'h0400, 1'b1, 1'b1};
    aset[0] = 14'h0000; aset[1] = 14'h0010; aset[2] = 14'h0123; aset[3] = 14'h1FFF;

    ctl_mem[23'h004123] = 8'hA5;
    ref_mem[23'h004123] = 8'hA5;

    rst_n = 1'b0; enable = 1'b1; mirror_mode = 2'd0; chr_bank = 4'd2;
    ppu_addr = 14'h2000; ppu_rd_n = 1'b1; ppu_we_n = 1'b1; ppu_din = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset doe", 32'(doe), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset req", 32'(mem_req), 32'd0);
    chk("reset rw", 32'(mem_rw), 32'd0);
    chk("reset addr", 32'(mem_addr), 32'd0);
    chk("reset wdata", 32'(mem_wdata), 32'd0);
    chk("reset late", 32'(late), 32'd0);
    $display("reset outputs checked");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // mirroring table
    foreach (vt[i]) begin
      @(negedge clk);
      mirror_mode = vt[i].mode; ppu_addr = vt[i].addr;
      #1;
      chk($sformatf("mirror%0d a10", i), 32'(a10_n), 32'(vt[i].a10));
      chk($sformatf("mirror%0d cs", i), 32'(cs_n), 32'(vt[i].cs));
      $display("mirror mode=%0d addr=%04h a10_n=%0b cs_n=%0b", vt[i].mode, vt[i].addr, a10_n, cs_n);
    end
    @(negedge clk);
    mirror_mode = 2'd0; ppu_addr = 14'h2000;
    ref_valid = 1'b0;
    repeat (3) @(negedge clk);

    // first read, then a repeat (hit), then a bank change (miss)
    lat = 3;
    chr_read(14'h0123, "first");
    chk("first mem_addr", 32'(last_rd_addr), 32'h4123);
    chk("base wrap addr", 32'(d2_last_addr), 32'h003123);
    chr_read(14'h0123, "repeat hit");
    set_bank(4'd3);
    chr_read(14'h0123, "bank3");
    chk("bank3 mem_addr", 32'(last_rd_addr), 32'h6123);

    // enable dropped while data is being driven
    @(negedge clk);
    ppu_addr = 14'h0123; ppu_rd_n = 1'b0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (doe) begin got = 1'b1; break; end
    end
    enable = 1'b0;
    #1;
    chk("en-drop got doe", 32'(got), 32'd1);
    chk("en-drop doe", 32'(doe), 32'd0);
    @(negedge clk);
    ppu_rd_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("enable-drop during hold: doe=%0b", doe);

    // disabled: a read issues no request
    r0 = rd_cnt; doe_hi = 0;
    @(negedge clk);
    ppu_addr = 14'h0456; ppu_rd_n = 1'b0;
    repeat (8) begin @(negedge clk); if (doe) doe_hi++; end
    ppu_rd_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("disabled requests", 32'(rd_cnt - r0), 32'd0);
    chk("disabled doe", 32'(doe_hi), 32'd0);
    $display("disabled read: requests=%0d", rd_cnt - r0);
    enable = 1'b1;

    // write-through and buffer invalidation
    set_bank(4'd0);
    chr_read(14'h0010, "pre-write");
    chr_write(14'h0010, 8'h3C, "wr 0x3C");
    chr_read(14'h0010, "post-write");
    chk("no-ram dut writes", 32'(d2_wr_seen), 32'd0);

    // randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      busy_hold = $urandom_range(0, 3);
      lat = $urandom_range(1, 5);
      a = aset[$urandom_range(0, 3)];
      if (op < 2) begin
        set_bank(4'($urandom_range(0, 3)));
        $display("bank  rand%0d bank=%0d", n, ref_bank);
      end else if (op < 4) begin
        wd = 8'($urandom);
        chr_write(a, wd, $sformatf("rand%0d", n));
      end else begin
        chr_read(a, $sformatf("rand%0d", n));
      end
    end
    chk("no-ram dut writes end", 32'(d2_wr_seen), 32'd0);

    // abort before acceptance: request held, data drained
    repeat (5) @(negedge clk);
    r0 = rd_cnt; doe_hi = 0; lat = 3;
    busy_hold = 14;
    @(negedge clk);
    ppu_addr = 14'h0777; ppu_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    ppu_rd_n = 1'b1;
    repeat (30) begin @(negedge clk); if (doe) doe_hi++; end
    chk("abort accepted", 32'(rd_cnt - r0), 32'd1);
    chk("abort doe", 32'(doe_hi), 32'd0);
    chk("abort late", 32'(late), 32'd1);
    chk("abort late2", 32'(late2), 32'd1);
    chk("req never dropped", 32'(drop_err), 32'd0);
    $display("abort read: late=%0d late2=%0d", late, late2);
    chr_read(14'h0777, "after drain");

    // strobe released while waiting for data: late, data still buffered
    lat = 12; doe_hi = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ppu_addr = 14'h0550 + 14'(k); ppu_rd_n = 1'b0;
      repeat (5) @(negedge clk);
      ppu_rd_n = 1'b1;
      repeat (25) begin @(negedge clk); if (doe) doe_hi++; end
      $display("late read %0d: late=%0d late2=%0d", k, late, late2);
    end
    ref_valid = 1'b1;
    ref_addr  = {6'b0, ref_bank, 13'h0553};
    chk("late doe", 32'(doe_hi), 32'd0);
    chk("late count", 32'(late), 32'd5);
    chk("late2 saturated", 32'(late2), 32'd3);
    lat = 3;
    chr_read(14'h0553, "late data hit");

    // reset while waiting for data
    lat = 10; r0 = rd_cnt;
    @(negedge clk);
    ppu_addr = 14'h0200; ppu_rd_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_cnt != r0) break;
    end
    chk("rst-test request", 32'(rd_cnt - r0), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async doe", 32'(doe), 32'd0);
    chk("async dout", 32'(dout), 32'd0);
    chk("async req", 32'(mem_req), 32'd0);
    chk("async rw", 32'(mem_rw), 32'd0);
    chk("async addr", 32'(mem_addr), 32'd0);
    chk("async wdata", 32'(mem_wdata), 32'd0);
    chk("async late", 32'(late), 32'd0);
    $display("async reset in wait: addr=%06h late=%0d", mem_addr, late);
    ppu_rd_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ref_valid = 1'b0;
    doe_hi = 0;
    repeat (20) begin @(negedge clk); if (doe || mem_req) doe_hi++; end
    chk("late rvalid ignored", 32'(doe_hi), 32'd0);
    lat = 3;
    chr_read(14'h0200, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
